// File: rtl/ppu_cpu_regs_if.sv
// CPU-side register bus between the 6502 core and the PPU register block.
// The CPU drives select/data/strobes; the PPU answers with read data.
interface ppu_cpu_regs_if;
  logic [2:0] addr;
  logic [7:0] ppu_reg_data;
  logic       ppu_reg_w;
  logic       ppu_reg_r;
  logic [7:0] reg_data_out;

  modport master (
    output addr, ppu_reg_data,
    output ppu_reg_w, ppu_reg_r,
    input  reg_data_out
  );

  modport slave (
    input  addr, ppu_reg_data,
    input  ppu_reg_w, ppu_reg_r,
    output reg_data_out
  );
endinterface

// File: rtl/ppu_cpu_regs.sv
// PPU register file ($2000-$2007): control, status, scroll, OAM/VRAM
// address ports, PPUDATA read buffer and NMI generation.
module ppu_cpu_regs #(
  parameter int VRAM_AW = 14,
  parameter int OAM_AW  = 8
) (
  input  logic               CLK,
  input  logic               RESET_n,
  ppu_cpu_regs_if.slave      bus,
  output logic               nmi_n,
  input  logic               vblank_set,
  input  logic               vblank_clr,
  input  logic               spr0_hit,
  input  logic               spr_ovf,
  output logic [7:0]         ppu_ctrl,
  output logic [7:0]         ppu_mask,
  output logic [7:0]         scroll_x,
  output logic [7:0]         scroll_y,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  output logic               vram_we,
  output logic               vram_re,
  input  logic [7:0]         vram_rdata,
  output logic [OAM_AW-1:0]  oam_addr,
  output logic [7:0]         oam_wdata,
  output logic               oam_we,
  input  logic [7:0]         oam_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CAPT  = 2'd2
  } state_e;

  state_e             state_q;
  logic [7:0]         ctrl_q, mask_q;
  logic [7:0]         sx_q, sy_q;
  logic [7:0]         latch_q, buf_q;
  logic               vbl_q, spr0_q, ovf_q;
  logic               toggle_q, nmi_n_q;
  logic [5:0]         hi_q;
  logic [VRAM_AW-1:0] vaddr_q, vaddr_d;
  logic [7:0]         vwdata_q, owdata_q;
  logic               vwe_q, owe_q;
  logic [OAM_AW-1:0]  oaddr_q;
  logic               vbl_d;
  logic [7:0]         ctrl_d;

  logic [7:0] data;
  logic [7:0] asel, ws, rs;
  logic       wr, rd;
  logic [VRAM_AW-1:0] inc;

  assign data = bus.ppu_reg_data;
  assign wr   = bus.ppu_reg_w;
  // a simultaneous write masks every read side effect
  assign rd   = bus.ppu_reg_r & ~bus.ppu_reg_w;
  assign asel = 8'b1 << bus.addr;
  assign ws   = asel & {8{wr}};
  assign rs   = asel & {8{rd}};
  assign inc  = ctrl_q[2] ? VRAM_AW'(32) : VRAM_AW'(1);

  assign vram_re = rs[7] & (state_q == IDLE);

  always_comb begin
    bus.reg_data_out = latch_q;
    unique case (1'b1)
      asel[2]: bus.reg_data_out =
                 {vbl_q, spr0_q, ovf_q, latch_q[4:0]};
      asel[4]: bus.reg_data_out = oam_rdata;
      asel[7]: bus.reg_data_out = buf_q;
      default: ;
    endcase
  end

  always_comb begin
    vbl_d = vbl_q;
    if (vblank_clr | rs[2]) vbl_d = 1'b0;
    if (vblank_set)         vbl_d = 1'b1;
    ctrl_d = ws[0] ? data : ctrl_q;
  end

  // write and fetch increments can overlap when accesses crowd
  always_comb begin
    vaddr_d = vaddr_q;
    if (vwe_q)             vaddr_d = vaddr_d + inc;
    if (state_q == FETCH)  vaddr_d = vaddr_d + inc;
    if (ws[6] & toggle_q)  vaddr_d = VRAM_AW'({hi_q, data});
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      mask_q   <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      latch_q  <= '0;
      buf_q    <= '0;
      vbl_q    <= 1'b0;
      spr0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      toggle_q <= 1'b0;
      nmi_n_q  <= 1'b1;
      hi_q     <= '0;
      vaddr_q  <= '0;
      vwdata_q <= '0;
      owdata_q <= '0;
      vwe_q    <= 1'b0;
      owe_q    <= 1'b0;
      oaddr_q  <= '0;
    end else begin
      if (wr) latch_q <= data;
      ctrl_q  <= ctrl_d;
      if (ws[1]) mask_q <= data;
      vbl_q   <= vbl_d;
      nmi_n_q <= ~(vbl_d & ctrl_d[7]);
      if (spr0_hit)        spr0_q <= 1'b1;
      else if (vblank_clr) spr0_q <= 1'b0;
      if (spr_ovf)         ovf_q <= 1'b1;
      else if (vblank_clr) ovf_q <= 1'b0;

      if (rs[2])              toggle_q <= 1'b0;
      else if (ws[5] | ws[6]) toggle_q <= ~toggle_q;
      if (ws[5] & ~toggle_q)  sx_q <= data;
      if (ws[5] &  toggle_q)  sy_q <= data;
      if (ws[6] & ~toggle_q)  hi_q <= data[5:0];
      vaddr_q <= vaddr_d;

      vwe_q <= ws[7];
      if (ws[7]) vwdata_q <= data;
      owe_q <= ws[4];
      if (ws[4]) owdata_q <= data;
      if (ws[3])      oaddr_q <= OAM_AW'(data);
      else if (owe_q) oaddr_q <= oaddr_q + OAM_AW'(1);

      case (state_q)
        IDLE:  if (vram_re) state_q <= FETCH;
        FETCH: begin
          buf_q   <= vram_rdata;
          state_q <= CAPT;
        end
        CAPT:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign nmi_n      = nmi_n_q;
  assign ppu_ctrl   = ctrl_q;
  assign ppu_mask   = mask_q;
  assign scroll_x   = sx_q;
  assign scroll_y   = sy_q;
  assign vram_addr  = vaddr_q;
  assign vram_wdata = vwdata_q;
  assign vram_we    = vwe_q;
  assign oam_addr   = oaddr_q;
  assign oam_wdata  = owdata_q;
  assign oam_we     = owe_q;

endmodule

// File: tb/tb_ppu_cpu_regs.sv
// Directed bench for ppu_cpu_regs: register table plus
// hand sequences for VRAM, status, NMI and reset corners.
module tb_ppu_cpu_regs;
  logic        CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic        nmi_n;
  logic        vblank_set, vblank_clr;
  logic        spr0_hit, spr_ovf;
  logic [7:0]  ppu_ctrl, ppu_mask;
  logic [7:0]  scroll_x, scroll_y;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata, vram_rdata;
  logic        vram_we, vram_re;
  logic [7:0]  oam_addr, oam_wdata, oam_rdata;
  logic        oam_we;

  ppu_cpu_regs_if bus ();

  ppu_cpu_regs #(.VRAM_AW(14), .OAM_AW(8)) dut (
    .CLK        (CLK),
    .RESET_n    (RESET_n),
    .bus        (bus),
    .nmi_n      (nmi_n),
    .vblank_set (vblank_set),
    .vblank_clr (vblank_clr),
    .spr0_hit   (spr0_hit),
    .spr_ovf    (spr_ovf),
    .ppu_ctrl   (ppu_ctrl),
    .ppu_mask   (ppu_mask),
    .scroll_x   (scroll_x),
    .scroll_y   (scroll_y),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .vram_re    (vram_re),
    .vram_rdata (vram_rdata),
    .oam_addr   (oam_addr),
    .oam_wdata  (oam_wdata),
    .oam_we     (oam_we),
    .oam_rdata  (oam_rdata)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] rdv;
  logic       rev;

  typedef struct {
    logic       w;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] rd;
    logic [7:0] ctrl;
    logic [7:0] mask;
    logic [7:0] sx;
    logic [7:0] sy;
    logic [7:0] oam;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // called on a falling edge; returns on the next one
  task automatic cyc(input logic w, input logic r,
                     input logic [2:0] a, input logic [7:0] d);
    bus.ppu_reg_w    = w;
    bus.ppu_reg_r    = r;
    bus.addr         = a;
    bus.ppu_reg_data = d;
    #1;
    rdv = bus.reg_data_out;
    rev = vram_re;
    @(negedge CLK);
    bus.ppu_reg_w = 1'b0;
    bus.ppu_reg_r = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cyc(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(1'b0, 1'b1, a, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ppu_reg_w = 1'b0;
    bus.ppu_reg_r = 1'b0;
    bus.addr = 3'd0;
    bus.ppu_reg_data = 8'h00;
    vblank_set = 1'b0;
    vblank_clr = 1'b0;
    spr0_hit = 1'b0;
    spr_ovf = 1'b0;
    vram_rdata = 8'h00;
    oam_rdata = 8'hC3;

    //            w   a  d      rd     ctrl   mask   sx     sy     oam
    tbl[0]  = '{1'b1, 0, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 1, 8'h1E, 8'h00, 8'h04, 8'h1E, 8'h00, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 0, 8'h00, 8'h1E, 8'h04, 8'h1E, 8'h00, 8'h00, 8'h00};
    tbl[3]  = '{1'b1, 5, 8'h12, 8'h00, 8'h04, 8'h1E, 8'h12, 8'h00, 8'h00};
    tbl[4]  = '{1'b1, 5, 8'h34, 8'h00, 8'h04, 8'h1E, 8'h12, 8'h34, 8'h00};
    tbl[5]  = '{1'b0, 5, 8'h00, 8'h34, 8'h04, 8'h1E, 8'h12, 8'h34, 8'h00};
    tbl[6]  = '{1'b1, 3, 8'hFF, 8'h00, 8'h04, 8'h1E, 8'h12, 8'h34, 8'hFF};
    tbl[7]  = '{1'b1, 4, 8'hAB, 8'h00, 8'h04, 8'h1E, 8'h12, 8'h34, 8'h00};
    tbl[8]  = '{1'b0, 4, 8'h00, 8'hC3, 8'h04, 8'h1E, 8'h12, 8'h34, 8'h00};
    tbl[9]  = '{1'b0, 2, 8'h00, 8'h0B, 8'h04, 8'h1E, 8'h12, 8'h34, 8'h00};
    tbl[10] = '{1'b1, 0, 8'h00, 8'h00, 8'h00, 8'h1E, 8'h12, 8'h34, 8'h00};
    tbl[11] = '{1'b1, 5, 8'h56, 8'h00, 8'h00, 8'h1E, 8'h56, 8'h34, 8'h00};
    tbl[12] = '{1'b0, 2, 8'h00, 8'h16, 8'h00, 8'h1E, 8'h56, 8'h34, 8'h00};
    tbl[13] = '{1'b1, 5, 8'h78, 8'h00, 8'h00, 8'h1E, 8'h78, 8'h34, 8'h00};

    repeat (3) @(negedge CLK);
    RESET_n = 1'b1;
    @(negedge CLK);

    chk("rst ctrl", 16'(ppu_ctrl), 16'h0);
    chk("rst mask", 16'(ppu_mask), 16'h0);
    chk("rst sx", 16'(scroll_x), 16'h0);
    chk("rst sy", 16'(scroll_y), 16'h0);
    chk("rst vaddr", 16'(vram_addr), 16'h0);
    chk("rst oaddr", 16'(oam_addr), 16'h0);
    chk("rst strobes",
        16'({vram_we, vram_re, oam_we}), 16'h0);
    chk("rst wdata",
        {vram_wdata, oam_wdata}, 16'h0);
    chk("rst nmi_n", 16'(nmi_n), 16'h1);
    rd(3'd2);
    chk("rst 2002", 16'(rdv), 16'h00);

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].w, ~tbl[i].w, tbl[i].a, tbl[i].d);
      idle(1);
      if (!tbl[i].w)
        chk($sformatf("v%0d rd", i), 16'(rdv), 16'(tbl[i].rd));
      chk($sformatf("v%0d ctrl", i),
          16'(ppu_ctrl), 16'(tbl[i].ctrl));
      chk($sformatf("v%0d mask", i),
          16'(ppu_mask), 16'(tbl[i].mask));
      chk($sformatf("v%0d sx", i),
          16'(scroll_x), 16'(tbl[i].sx));
      chk($sformatf("v%0d sy", i),
          16'(scroll_y), 16'(tbl[i].sy));
      chk($sformatf("v%0d oam", i),
          16'(oam_addr), 16'(tbl[i].oam));
    end

    rd(3'd2);
    chk("clr toggle rd", 16'(rdv), 16'h18);

    wr(3'd6, 8'h21);
    wr(3'd6, 8'h08);
    chk("2006 addr", 16'(vram_addr), 16'h2108);
    wr(3'd7, 8'hAA);
    chk("2007w we", 16'(vram_we), 16'h1);
    chk("2007w addr", 16'(vram_addr), 16'h2108);
    chk("2007w data", 16'(vram_wdata), 16'h00AA);
    idle(1);
    chk("2007w we off", 16'(vram_we), 16'h0);
    chk("2007w inc", 16'(vram_addr), 16'h2109);

    wr(3'd0, 8'h04);
    wr(3'd6, 8'h3F);
    wr(3'd6, 8'hF0);
    chk("3FF0 addr", 16'(vram_addr), 16'h3FF0);
    vram_rdata = 8'h55;
    rd(3'd7);
    chk("rd1 data", 16'(rdv), 16'h00);
    chk("rd1 re", 16'(rev), 16'h1);
    idle(1);
    chk("rd1 wrap", 16'(vram_addr), 16'h0010);
    idle(1);
    vram_rdata = 8'h66;
    rd(3'd7);
    chk("rd2 data", 16'(rdv), 16'h55);
    idle(2);
    chk("rd2 addr", 16'(vram_addr), 16'h0030);

    vram_rdata = 8'h77;
    rd(3'd7);
    chk("rd3 data", 16'(rdv), 16'h66);
    rd(3'd7);
    chk("busy rd data", 16'(rdv), 16'h66);
    chk("busy rd re", 16'(rev), 16'h0);
    idle(1);
    chk("busy addr", 16'(vram_addr), 16'h0050);
    rd(3'd7);
    chk("rd4 data", 16'(rdv), 16'h77);
    idle(3);

    wr(3'd0, 8'h00);
    vblank_set = 1'b1;
    @(negedge CLK);
    vblank_set = 1'b0;
    chk("nmi masked", 16'(nmi_n), 16'h1);
    wr(3'd0, 8'h80);
    chk("nmi on", 16'(nmi_n), 16'h0);
    rd(3'd2);
    chk("vbl rd", 16'(rdv), 16'h80);
    chk("nmi off", 16'(nmi_n), 16'h1);
    rd(3'd2);
    chk("vbl cleared", 16'(rdv), 16'h00);

    vblank_set = 1'b1;
    rd(3'd2);
    vblank_set = 1'b0;
    chk("race rd", 16'(rdv), 16'h00);
    chk("race nmi", 16'(nmi_n), 16'h0);
    rd(3'd2);
    chk("race later", 16'(rdv), 16'h80);

    spr0_hit = 1'b1;
    spr_ovf = 1'b1;
    vblank_set = 1'b1;
    @(negedge CLK);
    {spr0_hit, spr_ovf, vblank_set} = 3'b000;
    rd(3'd2);
    chk("status all", 16'(rdv), 16'h00E0);
    rd(3'd2);
    chk("status no vbl", 16'(rdv), 16'h0060);
    vblank_clr = 1'b1;
    @(negedge CLK);
    vblank_clr = 1'b0;
    rd(3'd2);
    chk("status clr", 16'(rdv), 16'h00);
    vblank_set = 1'b1;
    vblank_clr = 1'b1;
    @(negedge CLK);
    {vblank_set, vblank_clr} = 2'b00;
    rd(3'd2);
    chk("set beats clr", 16'(rdv), 16'h80);
    vblank_set = 1'b1;
    @(negedge CLK);
    vblank_set = 1'b0;
    cyc(1'b1, 1'b1, 3'd2, 8'h00);
    rd(3'd2);
    chk("w wins over r", 16'(rdv), 16'h80);

    wr(3'd3, 8'h10);
    wr(3'd4, 8'h5A);
    chk("oam we", 16'(oam_we), 16'h1);
    chk("oam wdata", 16'(oam_wdata), 16'h5A);
    chk("oam addr pre", 16'(oam_addr), 16'h10);
    idle(1);
    chk("oam we off", 16'(oam_we), 16'h0);
    chk("oam addr inc", 16'(oam_addr), 16'h11);

    vram_rdata = 8'h99;
    rd(3'd7);
    chk("pre-rst rd", 16'(rdv), 16'h77);
    RESET_n = 1'b0;
    #2;
    RESET_n = 1'b1;
    @(negedge CLK);
    chk("rst nmi again", 16'(nmi_n), 16'h1);
    rd(3'd7);
    chk("fetch dropped", 16'(rdv), 16'h00);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
